// File: rtl/bsg_wormhole_router_pkg.sv
// Shared definitions for the wormhole router slice.
//   ocl_state_e : output-control FSM state (idle = arbitrating, busy = locked mid-packet)
package bsg_wormhole_router_pkg;

  typedef enum logic [0:0] {
    e_ocl_idle = 1'b0,
    e_ocl_busy = 1'b1
  } ocl_state_e;

endpackage

// File: rtl/bsg_wormhole_router_output_control_len_if.sv
// Handshake bundle between the input directions and one output-port controller.
//   reqs_i     : per-input header request for this output
//   len_i      : per-input body-flit count, slice i belongs to input i
//   valid_i    : per-input flit valid
//   ready_i    : downstream can accept a flit
//   yumi_o     : per-input flit consumed (one-hot or zero)
//   valid_o    : a flit moves downstream this cycle
//   data_sel_o : one-hot data-mux select (or zero)
//   tag_o      : binary index of data_sel_o
//   busy_o     : output locked mid-packet
// master = request side (inputs / bench), slave = the controller.
interface bsg_wormhole_router_output_control_len_if #(
  parameter int dirs_p       = 5,
  parameter int len_width_p  = 4,
  parameter int tag_width_lp = $clog2(dirs_p)
);

  logic [dirs_p-1:0]             reqs_i;
  logic [dirs_p*len_width_p-1:0] len_i;
  logic [dirs_p-1:0]             valid_i;
  logic                          ready_i;
  logic [dirs_p-1:0]             yumi_o;
  logic                          valid_o;
  logic [dirs_p-1:0]             data_sel_o;
  logic [tag_width_lp-1:0]       tag_o;
  logic                          busy_o;

  modport master (
    output reqs_i, len_i, valid_i, ready_i,
    input  yumi_o, valid_o, data_sel_o, tag_o, busy_o
  );

  modport slave (
    input  reqs_i, len_i, valid_i, ready_i,
    output yumi_o, valid_o, data_sel_o, tag_o, busy_o
  );

endinterface

// File: rtl/bsg_wormhole_rr_pick.sv
// Combinational round-robin picker.
//   reqs  : request vector
//   last  : index of the previous winner; search starts at last+1 and wraps
//   grant : one-hot winner (zero when no request)
//   tag   : binary index of the winner (zero when no request)
//   v     : some request was granted
module bsg_wormhole_rr_pick #(
  parameter int dirs_p       = 5,
  parameter int tag_width_lp = $clog2(dirs_p)
) (
  input  logic [dirs_p-1:0]       reqs,
  input  logic [tag_width_lp-1:0] last,
  output logic [dirs_p-1:0]       grant,
  output logic [tag_width_lp-1:0] tag,
  output logic                    v
);

  localparam int unsigned dirs_lp = dirs_p;

  logic [tag_width_lp-1:0] idx;

  always_comb begin
    grant = '0;
    tag   = '0;
    v     = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= dirs_lp; off++) begin
      idx = tag_width_lp'((32'(last) + off) % dirs_lp);
      if (!v && reqs[idx]) begin
        v          = 1'b1;
        grant[idx] = 1'b1;
        tag        = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_wormhole_router_output_control_len.sv
// Output-port controller: round-robin arbitration among dirs_p inputs, locking
// the output to the winner for a whole packet whose body length is sampled
// from len_i on the header flit.
//   clk_i   : clock
//   reset_i : synchronous, active-low reset; all outputs are forced to 0 while low
//   ctl     : handshake bundle (see bsg_wormhole_router_output_control_len_if)
module bsg_wormhole_router_output_control_len
  import bsg_wormhole_router_pkg::*;
#(
  parameter int dirs_p       = 5,
  parameter int len_width_p  = 4,
  parameter int tag_width_lp = $clog2(dirs_p)
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_wormhole_router_output_control_len_if.slave ctl
);

  ocl_state_e              state_r, state_n;
  logic [dirs_p-1:0]       owner_r, owner_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n;
  logic [tag_width_lp-1:0] last_r, last_n;

  logic [dirs_p-1:0]       pick_grant;
  logic [tag_width_lp-1:0] pick_tag;
  logic                    pick_v;

  logic [dirs_p-1:0]       sel;
  logic                    xfer;
  logic [len_width_p-1:0]  win_len;

  bsg_wormhole_rr_pick #(
    .dirs_p      (dirs_p),
    .tag_width_lp(tag_width_lp)
  ) pick (
    .reqs (ctl.reqs_i),
    .last (last_r),
    .grant(pick_grant),
    .tag  (pick_tag),
    .v    (pick_v)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= e_ocl_idle;
      owner_r <= '0;
      cnt_r   <= '0;
      last_r  <= '0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      cnt_r   <= cnt_n;
      last_r  <= last_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    cnt_n   = cnt_r;
    last_n  = last_r;
    win_len = '0;
    for (int unsigned i = 0; i < dirs_p; i++) begin
      if (pick_grant[i]) win_len = ctl.len_i[i*len_width_p +: len_width_p];
    end
    unique case (state_r)
      e_ocl_idle: begin
        // xfer in idle implies pick_v: sel is the picker grant here
        if (xfer && pick_v) begin
          last_n = pick_tag;
          if (win_len != '0) begin
            owner_n = pick_grant;
            cnt_n   = win_len;
            state_n = e_ocl_busy;
          end
        end
      end
      e_ocl_busy: begin
        if (xfer) begin
          cnt_n = cnt_r - 1'b1;
          if (cnt_r == len_width_p'(1)) state_n = e_ocl_idle;
        end
      end
      default: state_n = e_ocl_idle;
    endcase
  end

  // Output logic
  always_comb begin
    sel = (state_r == e_ocl_busy) ? owner_r : pick_grant;
    if (!reset_i) sel = '0;
    xfer           = ctl.ready_i & (|(sel & ctl.valid_i));
    ctl.data_sel_o = sel;
    ctl.yumi_o     = sel & ctl.valid_i & {dirs_p{ctl.ready_i}};
    ctl.valid_o    = xfer;
    ctl.busy_o     = reset_i & (state_r == e_ocl_busy);
    ctl.tag_o      = '0;
    for (int unsigned i = 0; i < dirs_p; i++) begin
      if (sel[i]) ctl.tag_o = tag_width_lp'(i);
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_router_output_control_len.sv
// Directed bench for bsg_wormhole_router_output_control_len (dirs_p=5, len_width_p=4).
module tb_bsg_wormhole_router_output_control_len;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  bsg_wormhole_router_output_control_len_if #(.dirs_p(5), .len_width_p(4)) ctl ();

  bsg_wormhole_router_output_control_len #(.dirs_p(5), .len_width_p(4)) dut (
    .clk_i  (clk),
    .reset_i(reset_n),
    .ctl    (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] sel, input logic [4:0] yumi,
                            input logic vo, input logic [2:0] tg, input logic bz);
    chk({tag, ".sel"},   32'(ctl.data_sel_o), 32'(sel));
    chk({tag, ".yumi"},  32'(ctl.yumi_o),     32'(yumi));
    chk({tag, ".valid"}, 32'(ctl.valid_o),    32'(vo));
    chk({tag, ".tag"},   32'(ctl.tag_o),      32'(tg));
    chk({tag, ".busy"},  32'(ctl.busy_o),     32'(bz));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [19:0] mk_len(input int i, input logic [3:0] v);
    logic [19:0] r;
    r = '0;
    r[i*4 +: 4] = v;
    return r;
  endfunction

  initial begin
    int tseq[6];
    tseq = '{1, 2, 3, 4, 0, 1};

    // reset with every input high
    reset_n     = 1'b0;
    ctl.reqs_i  = '1;
    ctl.len_i   = '1;
    ctl.valid_i = '1;
    ctl.ready_i = 1'b1;
    tick();
    tick();
    expect_out("rst", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);

    reset_n    = 1'b1;
    ctl.reqs_i = '0;
    ctl.len_i  = '0;
    settle();
    expect_out("idle", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);
    tick();

    // 4-flit packet on input 2
    ctl.reqs_i = 5'b00100;
    ctl.len_i  = mk_len(2, 4'd3);
    settle();
    expect_out("p2.hdr", 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b0);
    tick();
    ctl.reqs_i = '0;
    for (int k = 0; k < 3; k++) begin
      settle();
      expect_out("p2.body", 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1);
      tick();
    end
    settle();
    expect_out("p2.after", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);

    // fresh pointer, round-robin of single-flit packets
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    ctl.reqs_i = '1;
    ctl.len_i  = '0;
    for (int k = 0; k < 6; k++) begin
      settle();
      expect_out("rr", 5'(1 << tseq[k]), 5'(1 << tseq[k]), 1'b1, 3'(tseq[k]), 1'b0);
      tick();
    end
    ctl.reqs_i = '0;

    // input 3, length 2, stall on first body cycle
    ctl.reqs_i = 5'b01000;
    ctl.len_i  = mk_len(3, 4'd2);
    settle();
    expect_out("stall.hdr", 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b0);
    tick();
    ctl.reqs_i  = '0;
    ctl.ready_i = 1'b0;
    settle();
    expect_out("stall.hold", 5'b01000, 5'b00000, 1'b0, 3'd3, 1'b1);
    tick();
    ctl.ready_i = 1'b1;
    settle();
    expect_out("stall.b1", 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1);
    tick();
    settle();
    expect_out("stall.tail", 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1);
    tick();
    settle();
    expect_out("stall.after", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);

    // requests during BUSY are ignored; input 4 wins afterwards
    ctl.reqs_i = 5'b01000;
    ctl.len_i  = mk_len(3, 4'd2);
    settle();
    expect_out("lock.hdr", 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b0);
    tick();
    ctl.reqs_i = 5'b00010;
    ctl.len_i  = '0;
    settle();
    expect_out("lock.b1", 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1);
    tick();
    settle();
    expect_out("lock.tail", 5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1);
    tick();
    ctl.reqs_i  = 5'b10010;
    ctl.valid_i = 5'b01111;
    settle();
    expect_out("lock.w4", 5'b10000, 5'b00000, 1'b0, 3'd4, 1'b0);
    tick();
    // input 4 dropped before commit: pointer still 3, input 1 wins
    ctl.reqs_i  = 5'b00010;
    ctl.valid_i = '1;
    settle();
    expect_out("lock.w1", 5'b00010, 5'b00010, 1'b1, 3'd1, 1'b0);
    tick();

    // reset mid-packet with cnt_r = 5
    ctl.reqs_i = 5'b00001;
    ctl.len_i  = mk_len(0, 4'd7);
    settle();
    expect_out("mid.hdr", 5'b00001, 5'b00001, 1'b1, 3'd0, 1'b0);
    tick();
    ctl.reqs_i = '0;
    for (int k = 0; k < 2; k++) begin
      settle();
      expect_out("mid.body", 5'b00001, 5'b00001, 1'b1, 3'd0, 1'b1);
      tick();
    end
    reset_n = 1'b0;
    settle();
    expect_out("mid.rst", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    settle();
    expect_out("mid.rel", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);
    ctl.reqs_i = '1;
    ctl.len_i  = '0;
    settle();
    expect_out("mid.ptr", 5'b00010, 5'b00010, 1'b1, 3'd1, 1'b0);
    tick();
    ctl.reqs_i = '0;

    // maximum packet: header + 15 body flits
    ctl.reqs_i = 5'b00100;
    ctl.len_i  = mk_len(2, 4'd15);
    settle();
    expect_out("max.hdr", 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b0);
    tick();
    ctl.reqs_i = '0;
    for (int k = 0; k < 15; k++) begin
      settle();
      expect_out("max.body", 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1);
      tick();
    end
    settle();
    expect_out("max.after", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
